gate_bist_driver: RTL

- Built-in self-test driver for the combinational gate-model netlists (18 inputs, 10 outputs) in the simulator gate library.
- Upstream side: an LFSR generates pseudo-random 18-bit input vectors and drives them into the netlist inputs N1..N18.
- Downstream side: a MISR compacts the 10-bit netlist response into a signature, which is compared against a golden value.
- A small FSM sequences each run and reports done/pass to the lab controller.

---
 rtl/gate_bist_pkg.sv | 28 ++
 rtl/gate_misr.sv | 43 ++++
 rtl/gate_bist_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg
// Shared definitions for the gate-model BIST driver: default data widths,
// the feedback tap positions of the pattern LFSR and the response MISR,
// and the sequencing FSM state type.
// No ports (package only).

package gate_bist_pkg;

  // Netlist interface widths: 18 inputs (N1..N18) and 10 outputs
  localparam int IN_W_DEFAULT  = 18;
  localparam int OUT_W_DEFAULT = 10;

  // Pattern LFSR, x^18 + x^11 + 1
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 10;

  // Response MISR, x^10 + x^7 + 1
  localparam int MISR_TAP_HI = 9;
  localparam int MISR_TAP_LO = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/gate_misr.sv
// gate_misr
// Multiple-input signature register that compacts the netlist response
// into a running signature.
// Ports:
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset, clears the signature
//   i_clear   clears the signature at the start of a run
//   i_enable  folds i_data into the signature
//   i_data    netlist response word
//   o_sig     current signature

module gate_misr
  import gate_bist_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [OUT_W-1:0] i_data,
  output logic [OUT_W-1:0] o_sig
);

  logic [OUT_W-1:0] r_sig;
  logic             w_feedback;

  assign w_feedback = r_sig[MISR_TAP_HI] ^ r_sig[MISR_TAP_LO];

  // Clear wins over enable so a restart never folds a stale response in
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_enable) begin
      r_sig <= {r_sig[OUT_W-2:0], w_feedback} ^ i_data;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/gate_bist_driver.sv
// gate_bist_driver
// Built-in self-test driver for an 18-input / 10-output combinational gate
// netlist. An LFSR drives pseudo-random patterns into the netlist, a MISR
// compacts the responses, and a small FSM sequences APPLY/CAPTURE pairs
// for PAT_COUNT patterns before reporting done/pass.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_start      one-cycle run request, honoured in IDLE or DONE
//   i_abort      return to IDLE, pattern and signature held
//   i_golden     expected signature, compared while done
//   i_resp       netlist outputs for the current pattern
//   o_pat        registered pattern driven to netlist N1..N18 (N1 = bit 0)
//   o_pat_valid  pattern is being applied (APPLY and CAPTURE)
//   o_busy       run in progress (APPLY and CAPTURE)
//   o_done       run finished
//   o_pass       signature matches golden while done
//   o_sig        current MISR signature

module gate_bist_driver
  import gate_bist_pkg::*;
#(
  parameter int              IN_W      = IN_W_DEFAULT,
  parameter int              OUT_W     = OUT_W_DEFAULT,
  parameter int              PAT_COUNT = 256,
  parameter logic [IN_W-1:0] LFSR_SEED = IN_W'(1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [OUT_W-1:0] i_golden,
  input  logic [OUT_W-1:0] i_resp,
  output logic [IN_W-1:0]  o_pat,
  output logic             o_pat_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [OUT_W-1:0] o_sig
);

  localparam int              CNT_W    = $clog2(PAT_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAT_COUNT - 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1
  localparam logic [IN_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

  state_t           r_state;
  logic [IN_W-1:0]  r_pat;
  logic [CNT_W-1:0] r_count;
  logic             r_pat_valid;
  logic             r_busy;
  logic             r_done;

  logic [IN_W-1:0]  w_lfsr_next;
  logic             w_start_ok;
  logic             w_misr_clear;
  logic             w_misr_en;
  logic [OUT_W-1:0] w_sig;

  assign w_lfsr_next = {r_pat[IN_W-2:0], r_pat[LFSR_TAP_HI] ^ r_pat[LFSR_TAP_LO]};
  assign w_start_ok  = i_start && ((r_state == IDLE) || (r_state == DONE));

  // Abort freezes the signature, so it suppresses both clear and capture
  assign w_misr_clear = !i_abort && w_start_ok;
  assign w_misr_en    = !i_abort && (r_state == CAPTURE);

  gate_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_misr_clear),
    .i_enable (w_misr_en),
    .i_data   (i_resp),
    .o_sig    (w_sig)
  );

  // Sequencer: each pattern gets an APPLY settle cycle followed by a
  // CAPTURE cycle whose closing edge folds the response and steps the LFSR.
  // Abort beats start; status outputs are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_count     <= '0;
      r_pat_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (i_abort) begin
      r_state     <= IDLE;
      r_pat_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state     <= APPLY;
            r_pat       <= SEED_EFF;
            r_count     <= '0;
            r_pat_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        APPLY: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_pat <= w_lfsr_next;
          if (r_count == LAST_IDX) begin
            r_state     <= DONE;
            r_pat_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
            r_state <= APPLY;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_pat       = r_pat;
  assign o_pat_valid = r_pat_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sig       = w_sig;
  // Combinational so a new golden value is reflected without waiting a cycle
  assign o_pass      = r_done && (w_sig == i_golden);

endmodule
